instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the control decoder. Owns the PC and issues word reads to
//  the BIOS and IMEM synchronous-read memories. Returns {instr, pc, valid} to

---
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit_if: fetch-stage memory and decode bundle -- rev 1.0
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int BIOS_AW = 12,
  parameter int IMEM_AW = 14
);
  logic               stall;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               bios_en;
  logic [BIOS_AW-1:0] bios_addr;
  logic [31:0]        bios_dout;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_dout;
  logic [31:0]        instr;
  logic [31:0]        instr_pc;
  logic               instr_valid;
  logic               fetch_fault;
  logic [31:0]        fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, bios_dout, imem_dout,
    output bios_en, bios_addr, imem_en, imem_addr,
    output instr, instr_pc, instr_valid, fetch_fault, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, bios_dout, imem_dout,
    input  bios_en, bios_addr, imem_en, imem_addr,
    input  instr, instr_pc, instr_valid, fetch_fault, fetch_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit: PC owner and BIOS/IMEM fetch stage -- rev 1.0
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          BIOS_AW   = 12,
  parameter int          IMEM_AW   = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam logic [1:0] SRC_BIOS = 2'd0;
  localparam logic [1:0] SRC_IMEM = 2'd1;
  localparam logic [1:0] SRC_NONE = 2'd2;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  src_q, src_d;
  logic        vld_q, vld_d;
  logic        flt_q, flt_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_act_q, hold_act_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] req_pc;
  logic [1:0]  req_src;
  logic [31:0] live_dout;

  function automatic logic [1:0] decode_src(input logic [3:0] region);
    case (region)
      4'h4:    decode_src = SRC_BIOS;
      4'h1:    decode_src = SRC_IMEM;
      default: decode_src = SRC_NONE;
    endcase
  endfunction

  // Redirect beats stall; a stalled cycle re-issues pc_q so the memory keeps
  // presenting the same word.
  always_comb begin
    req_pc = pc_q;
    if (bus.redirect_valid) begin
      req_pc = {bus.redirect_pc[31:2], 2'b00};
    end else if (!bus.stall && vld_q) begin
      req_pc = pc_q + 32'd4;
    end
  end

  always_comb begin
    req_src = decode_src(req_pc[31:28]);
  end

  always_comb begin
    case (src_q)
      SRC_BIOS: live_dout = bus.bios_dout;
      SRC_IMEM: live_dout = bus.imem_dout;
      default:  live_dout = NOP_INSTR;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    src_d      = src_q;
    vld_d      = vld_q;
    flt_d      = flt_q;
    hold_d     = hold_q;
    hold_act_d = hold_act_q;
    if (bus.redirect_valid) begin
      pc_d       = req_pc;
      src_d      = req_src;
      vld_d      = 1'b1;
      flt_d      = (req_src == SRC_NONE) || (bus.redirect_pc[1:0] != 2'b00);
      hold_act_d = 1'b0;
    end else if (bus.stall) begin
      // Snapshot on the first stalled cycle so later memory writes cannot leak out.
      if (!hold_act_q) begin
        hold_d     = live_dout;
        hold_act_d = 1'b1;
      end
    end else begin
      pc_d       = req_pc;
      src_d      = req_src;
      vld_d      = 1'b1;
      flt_d      = (req_src == SRC_NONE);
      hold_act_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (vld_q && !bus.stall && !bus.redirect_valid) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      src_q      <= SRC_NONE;
      vld_q      <= 1'b0;
      flt_q      <= 1'b0;
      hold_q     <= NOP_INSTR;
      hold_act_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      src_q      <= src_d;
      vld_q      <= vld_d;
      flt_q      <= flt_d;
      hold_q     <= hold_d;
      hold_act_q <= hold_act_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.bios_en   = (req_pc[31:28] == 4'h4);
  assign bus.bios_addr = req_pc[BIOS_AW+1:2];
  assign bus.imem_en   = (req_pc[31:28] == 4'h1);
  assign bus.imem_addr = req_pc[IMEM_AW+1:2];

  always_comb begin
    if (!vld_q || flt_q) begin
      bus.instr = NOP_INSTR;
    end else if (hold_act_q) begin
      bus.instr = hold_q;
    end else begin
      bus.instr = live_dout;
    end
  end

  assign bus.instr_pc    = pc_q;
  assign bus.instr_valid = vld_q;
  assign bus.fetch_fault = vld_q & flt_q;
  assign bus.fetch_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit -- rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h4000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          BIOS_AW   = 12;
  localparam int          IMEM_AW   = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.BIOS_AW(BIOS_AW), .IMEM_AW(IMEM_AW)) bus ();

  instr_fetch_unit #(
    .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .BIOS_AW(BIOS_AW), .IMEM_AW(IMEM_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [31:0] bios_mem [0:(1<<BIOS_AW)-1];
  logic [31:0] imem_mem [0:(1<<IMEM_AW)-1];
  logic [31:0] bios_q = 32'd0;
  logic [31:0] imem_q = 32'd0;

  always @(posedge clk) begin
    if (bus.bios_en) bios_q <= bios_mem[bus.bios_addr];
    if (bus.imem_en) imem_q <= imem_mem[bus.imem_addr];
  end
  assign bus.bios_dout = bios_q;
  assign bus.imem_dout = imem_q;

  typedef struct {
    int unsigned cyc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // What decode should see when a word at pc is fetched right now.
  function automatic exp_t fetch_at(input logic [31:0] pc, input logic misaligned);
    exp_t e;
    e.cyc   = 0;
    e.cnt   = 0;
    e.valid = 1'b1;
    e.pc    = pc;
    e.fault = misaligned || !(pc[31:28] == 4'h4 || pc[31:28] == 4'h1);
    if (e.fault)                e.instr = NOP_INSTR;
    else if (pc[31:28] == 4'h4) e.instr = bios_mem[pc[BIOS_AW+1:2]];
    else                        e.instr = imem_mem[pc[IMEM_AW+1:2]];
    return e;
  endfunction

  task automatic drive(input logic r_n, input logic st, input logic rv, input logic [31:0] rpc);
    exp_t nxt;
    rst_n              = r_n;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (!r_n) begin
      nxt.valid = 1'b0; nxt.pc = RESET_PC; nxt.instr = NOP_INSTR;
      nxt.fault = 1'b0; nxt.cnt = 32'd0;
    end else begin
      if (rv)       nxt = fetch_at({rpc[31:2], 2'b00}, rpc[1:0] != 2'b00);
      else if (st)  nxt = cur;
      else          nxt = fetch_at(cur.valid ? cur.pc + 32'd4 : cur.pc, 1'b0);
      nxt.cnt = cur.cnt + ((cur.valid && !st && !rv) ? 32'd1 : 32'd0);
    end
    nxt.cyc = cyc + 1;
    exp_q.push_back(nxt);
    cur = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r_n, input logic st, input logic rv, input logic [31:0] rpc);
    drive(r_n, st, rv, rpc);
    tick();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.instr_valid === e.valid && bus.fetch_fault === e.fault &&
          bus.instr_pc === e.pc && bus.instr === e.instr && bus.fetch_count === e.cnt) begin
        n_pass++;
      end else begin
        $display("FAIL cycle%0d: got v=%b f=%b pc=%h instr=%h cnt=%0d, required v=%b f=%b pc=%h instr=%h cnt=%0d",
                 cyc, bus.instr_valid, bus.fetch_fault, bus.instr_pc, bus.instr, bus.fetch_count,
                 e.valid, e.fault, e.pc, e.instr, e.cnt);
      end
    end
  end

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 4))
      0:       rand_target = 32'h4000_0000 | $urandom_range(0, 32'h3FFF);
      1:       rand_target = 32'h1000_0000 | $urandom_range(0, 32'hFFFF);
      2:       rand_target = {4'h8, 28'(($urandom_range(0, 255)) << 2)};
      3:       rand_target = 32'h4000_3FF0 | $urandom_range(0, 15);
      default: rand_target = $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << BIOS_AW); i++) bios_mem[i] = $urandom();
    for (int i = 0; i < (1 << IMEM_AW); i++) imem_mem[i] = $urandom();
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);

    // First cycle out of reset fetches word 0 of BIOS.
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    check("bios_en_after_reset", {31'd0, bus.bios_en}, 32'd1);
    check("bios_addr_after_reset", {20'd0, bus.bios_addr}, 32'd0);
    tick();
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Stall at 0x4000_0008 while BIOS word 2 is rewritten.
    step(1'b1, 1'b0, 1'b1, 32'h4000_0008);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    bios_mem[2] = ~bios_mem[2];
    tick();
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);

    // Redirect into IMEM while stalled.
    drive(1'b1, 1'b1, 1'b1, 32'h1000_0040);
    #1;
    check("imem_en_on_redirect", {31'd0, bus.imem_en}, 32'd1);
    check("bios_en_on_redirect", {31'd0, bus.bios_en}, 32'd0);
    check("imem_addr_on_redirect", {18'd0, bus.imem_addr}, 32'h10);
    tick();
    step(1'b1, 1'b0, 1'b0, 32'd0);

    step(1'b1, 1'b0, 1'b1, 32'h8000_0000);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h4000_0006);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h1000_0000);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic r_n, st, rv;
      r_n = ($urandom_range(0, 99) >= 2);
      st  = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 5) bios_mem[cur.pc[BIOS_AW+1:2]] = $urandom();
      if ($urandom_range(0, 99) < 5) imem_mem[cur.pc[IMEM_AW+1:2]] = $urandom();
      step(r_n, st, rv, rand_target());
    end

    step(1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
